u_rec_fifo: RTL

- Downstream consumer of the UART receiver. Turns its level-style ready output (rec_readyH) into one clean write strobe per received byte.
- Buffers the bytes in a synchronous first-word-fall-through FIFO for the host-side logic.
- Ignores false starts: glitch frames abort back to idle with no new data, so they are filtered out by a minimum-low-time qualifier.
- Sits between the receiver's rec_dataH/rec_readyH and the system command logic, all on sys_clk.

---
 rtl/u_rec_fifo_pkg.sv | 23 ++
 rtl/u_rec_fifo_sync_fifo.sv | 79 +++++++
 rtl/u_rec_fifo.sv | 78 +++++++
 3 files changed

// File: rtl/u_rec_fifo_pkg.sv
// Shared constants and types for the UART receive buffer (successor of inc.h).
package u_rec_fifo_pkg;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int unsigned WORD_LEN        = 8;
  localparam int unsigned REC_FIFO_DEPTH  = 16;
  localparam int unsigned REC_FIFO_ADDR_W = 4;
  localparam int unsigned REC_MIN_LOW     = 128;
  localparam int unsigned REC_LOW_W       = 8;

  typedef logic [WORD_LEN-1:0] word_t;

  // Effective FIFO operation for one clock, after full/empty qualification.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/u_rec_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pushes while full are accepted only when a pop frees the slot in the same cycle.
module u_sync_fifo
  import u_rec_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = REC_FIFO_DEPTH,
  parameter int unsigned ADDR_W = REC_FIFO_ADDR_W,
  parameter int unsigned DATA_W = WORD_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;
  fifo_op_e          op;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    op = OP_IDLE;
    unique case ({do_push, do_pop})
      2'b01:   op = OP_POP;
      2'b10:   op = OP_PUSH;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == LO) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/u_rec_fifo.sv
// UART receive buffer: qualifies rec_readyH rises into byte strobes,
// stores bytes in a FWFT FIFO and flags bytes dropped while full.
module u_rec_fifo
  import u_rec_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = REC_FIFO_DEPTH,
  parameter int unsigned ADDR_W  = REC_FIFO_ADDR_W,
  parameter int unsigned MIN_LOW = REC_MIN_LOW,
  parameter int unsigned LOW_W   = REC_LOW_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic [WORD_LEN-1:0] rec_dataH,
  input  logic                rec_readyH,
  input  logic                rd_enH,
  output logic [WORD_LEN-1:0] rd_dataH,
  output logic                emptyH,
  output logic                fullH,
  output logic [ADDR_W:0]     fill_cntH,
  output logic                overflowH,
  input  logic                ovf_clrH
);

  localparam logic [LOW_W-1:0] LOW_THRESH = LOW_W'(MIN_LOW);

  logic             ready_d;
  logic [LOW_W-1:0] low_cnt;
  logic             wr_stbH;
  logic             ovf_set;

  // A rise only counts as a frame end after a full-length low run; short
  // runs (false starts, recovery from reset) fall below the threshold.
  assign wr_stbH = rec_readyH & ~ready_d & (low_cnt >= LOW_THRESH);

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (sys_rst_l == LO) begin
      ready_d <= HI;
      low_cnt <= '0;
    end else begin
      ready_d <= rec_readyH;
      if (rec_readyH) begin
        low_cnt <= '0;
      end else if (low_cnt != '1) begin
        low_cnt <= low_cnt + 1'b1;
      end
    end
  end

  // Full implies non-empty, so a read request here is always an effective pop.
  assign ovf_set = wr_stbH & fullH & ~rd_enH;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (sys_rst_l == LO) begin
      overflowH <= LO;
    end else if (ovf_set) begin
      overflowH <= HI;
    end else if (ovf_clrH) begin
      overflowH <= LO;
    end
  end

  u_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_LEN)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_l),
    .push      (wr_stbH),
    .push_data (rec_dataH),
    .pop       (rd_enH),
    .pop_data  (rd_dataH),
    .empty     (emptyH),
    .full      (fullH),
    .count     (fill_cntH)
  );

endmodule
